// File: rtl/i2c_sequence_initializer.sv
// Table-driven I2C init sequencer: walks a command ROM (write/delay/end) and drives a byte-level serial controller.
// Latency: 2 cycles per entry fetch/decode; backpressure: each byte/stop request holds until transfer_complete.
module i2c_sequence_initializer #(
  parameter int ROM_ADDR_W     = 6,
  parameter int NUM_BYTES      = 3,
  parameter int MAX_RETRIES    = 3,
  parameter int DELAY_PRESCALE = 1000,
  parameter int HALT_ON_ERROR  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      restart,
  input  logic                      clear_error,
  output logic [ROM_ADDR_W-1:0]     rom_address,
  input  logic [2+8*NUM_BYTES-1:0]  rom_data,
  input  logic                      ack,
  input  logic                      transfer_complete,
  output logic [7:0]                data_out,
  output logic                      transfer_data,
  output logic                      send_start_bit,
  output logic                      send_stop_bit,
  output logic                      init_busy,
  output logic                      init_complete,
  output logic                      init_error,
  output logic [ROM_ADDR_W-1:0]     error_index
);
  localparam int EW = 2 + 8*NUM_BYTES;
  localparam int BW = $clog2(NUM_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES-1);
  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);
  localparam logic [31:0] PRESCALE = 32'(DELAY_PRESCALE);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_XFER, S_WAITLOW, S_STOP, S_STOPLOW,
    S_NEXT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t                  state, state_nx;
  logic [ROM_ADDR_W-1:0]   index, index_nx;
  logic [8*NUM_BYTES-1:0]  payload, payload_nx;
  logic [BW-1:0]           byte_k, byte_k_nx;
  logic                    nack, nack_nx;
  logic [3:0]              retry, retry_nx;
  logic [31:0]             delay_cnt, delay_cnt_nx;
  logic                    err_set;
  logic [7:0]              cur_byte;

  assign rom_address   = index;
  assign init_complete = (state == S_DONE);

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++)
      if (byte_k == BW'(i)) cur_byte = payload[8*(NUM_BYTES-1-i) +: 8];
  end

  always_comb begin
    state_nx       = state;
    index_nx       = index;
    payload_nx     = payload;
    byte_k_nx      = byte_k;
    nack_nx        = nack;
    retry_nx       = retry;
    delay_cnt_nx   = delay_cnt;
    err_set        = 1'b0;
    transfer_data  = 1'b0;
    send_start_bit = 1'b0;
    send_stop_bit  = 1'b0;
    data_out       = '0;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        payload_nx   = rom_data[8*NUM_BYTES-1:0];
        byte_k_nx    = '0;
        nack_nx      = 1'b0;
        delay_cnt_nx = 32'(rom_data[15:0]) * PRESCALE;
        case (rom_data[EW-1 -: 2])
          2'b00:   state_nx = S_XFER;
          2'b01:   state_nx = (rom_data[15:0] == 16'd0) ? S_NEXT : S_DELAY;
          default: state_nx = S_DONE;
        endcase
      end
      S_XFER: begin
        transfer_data  = 1'b1;
        send_start_bit = (byte_k == '0);
        data_out       = cur_byte;
        if (transfer_complete) begin
          nack_nx  = nack | ack;
          state_nx = S_WAITLOW;
        end
      end
      S_WAITLOW: if (!transfer_complete) begin
        if (byte_k == LAST_BYTE) state_nx = S_STOP;
        else begin
          byte_k_nx = byte_k + BW'(1);
          state_nx  = S_XFER;
        end
      end
      S_STOP: begin
        send_stop_bit = 1'b1;
        if (transfer_complete) state_nx = S_STOPLOW;
      end
      // Whole transaction, stop included, is done before the NACK verdict.
      S_STOPLOW: if (!transfer_complete) begin
        if (!nack) state_nx = S_NEXT;
        else if (retry < MAX_R) begin
          retry_nx  = retry + 4'd1;
          byte_k_nx = '0;
          nack_nx   = 1'b0;
          state_nx  = S_XFER;
        end else begin
          err_set  = 1'b1;
          state_nx = (HALT_ON_ERROR != 0) ? S_ERROR : S_NEXT;
        end
      end
      S_DELAY: begin
        if (delay_cnt <= 32'd1) state_nx = S_NEXT;
        else delay_cnt_nx = delay_cnt - 32'd1;
      end
      S_NEXT: begin
        retry_nx = '0;
        if (index == '1) state_nx = S_DONE;
        else begin
          index_nx = index + 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_DONE, S_ERROR: if (restart) begin
        index_nx = '0;
        retry_nx = '0;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // busy is registered so it reads 0 while reset is held even though state sits in FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      index       <= '0;
      payload     <= '0;
      byte_k      <= '0;
      nack        <= 1'b0;
      retry       <= '0;
      delay_cnt   <= '0;
      init_busy   <= 1'b0;
      init_error  <= 1'b0;
      error_index <= '0;
    end else begin
      state     <= state_nx;
      index     <= index_nx;
      payload   <= payload_nx;
      byte_k    <= byte_k_nx;
      nack      <= nack_nx;
      retry     <= retry_nx;
      delay_cnt <= delay_cnt_nx;
      init_busy <= !(state_nx == S_DONE || state_nx == S_ERROR);
      if (err_set) begin
        init_error <= 1'b1;
        if (!init_error || clear_error) error_index <= index;
      end else if (clear_error) begin
        init_error  <= 1'b0;
        error_index <= '0;
      end
    end
  end
endmodule
